// File: rtl/rf_scoreboard.sv
// Register file with busy scoreboard for the pipelined RV32 core.
// Storage is swept to zero after reset so it can map onto a plain RAM.
module rf_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG),
  parameter bit BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            ready
);

  localparam logic [0:0]    ST_INIT  = 1'b0;
  localparam logic [0:0]    ST_RUN   = 1'b1;
  localparam logic [AW-1:0] ADDR_0   = {AW{1'b0}};
  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  logic [XLEN-1:0] mem_q [NREG];
  logic [0:0]      state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic [NREG-1:0] busy_q, busy_d;

  logic            mem_we_s;
  logic [AW-1:0]   mem_waddr_s;
  logic [XLEN-1:0] mem_wdata_s;
  logic            run_s;
  logic            wr_valid_s;

  assign run_s      = (state_q == ST_RUN);
  assign wr_valid_s = wr_en && (wr_addr != ADDR_0);

  // Next-state: init sweep, architectural writes and scoreboard update
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = cnt_q;
    mem_wdata_s = {XLEN{1'b0}};
    if (rst) begin
      state_d = ST_INIT;
      cnt_d   = ADDR_0;
      busy_d  = {NREG{1'b0}};
    end else begin
      case (state_q)
        ST_INIT: begin
          mem_we_s    = 1'b1;
          mem_waddr_s = cnt_q;
          mem_wdata_s = {XLEN{1'b0}};
          if (cnt_q == LAST_IDX) begin
            state_d = ST_RUN;
            cnt_d   = ADDR_0;
          end else begin
            cnt_d = cnt_q + {{(AW-1){1'b0}}, 1'b1};
          end
        end
        ST_RUN: begin
          if (wr_valid_s) begin
            mem_we_s          = 1'b1;
            mem_waddr_s       = wr_addr;
            mem_wdata_s       = wr_data;
            busy_d[wr_addr]   = 1'b0;
          end else begin
            mem_we_s = 1'b0;
          end
          // Applied after the clear so a new producer wins over retirement
          if (issue_en && (issue_rd != ADDR_0)) begin
            busy_d[issue_rd] = 1'b1;
          end else begin
            busy_d[issue_rd] = busy_d[issue_rd];
          end
        end
        default: begin
          state_d = ST_INIT;
          cnt_d   = ADDR_0;
          busy_d  = {NREG{1'b0}};
        end
      endcase
      busy_d[0] = 1'b0;
    end
    ready_d = (state_d == ST_RUN);
  end

  // Control and scoreboard registers
  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    busy_q  <= busy_d;
    ready_q <= ready_d;
  end

  // Storage: single write port, no reset so it can become a RAM
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Read port 1 with optional forwarding of the in-flight write
  always_comb begin
    rs1_data = {XLEN{1'b0}};
    rs1_busy = 1'b0;
    if (!run_s || (rs1_addr == ADDR_0)) begin
      rs1_data = {XLEN{1'b0}};
      rs1_busy = 1'b0;
    end else if (BYPASS && wr_valid_s && (wr_addr == rs1_addr)) begin
      rs1_data = wr_data;
      rs1_busy = 1'b0;
    end else begin
      rs1_data = mem_q[rs1_addr];
      rs1_busy = busy_q[rs1_addr];
    end
  end

  // Read port 2 with optional forwarding of the in-flight write
  always_comb begin
    rs2_data = {XLEN{1'b0}};
    rs2_busy = 1'b0;
    if (!run_s || (rs2_addr == ADDR_0)) begin
      rs2_data = {XLEN{1'b0}};
      rs2_busy = 1'b0;
    end else if (BYPASS && wr_valid_s && (wr_addr == rs2_addr)) begin
      rs2_data = wr_data;
      rs2_busy = 1'b0;
    end else begin
      rs2_data = mem_q[rs2_addr];
      rs2_busy = busy_q[rs2_addr];
    end
  end

  assign ready = ready_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Randomised bench for rf_scoreboard: a BYPASS=1 and a BYPASS=0 instance share
// stimulus and are compared every cycle against an array-based reference model.
module tb_rf_scoreboard;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   rs1_addr, rs2_addr, wr_addr, issue_rd;
  logic            wr_en, issue_en;
  logic [XLEN-1:0] wr_data;

  logic [XLEN-1:0] b_rs1_data, b_rs2_data, n_rs1_data, n_rs2_data;
  logic            b_rs1_busy, b_rs2_busy, n_rs1_busy, n_rs2_busy;
  logic            b_ready, n_ready;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state
  logic [XLEN-1:0] m_mem [NREG];
  bit              m_busy [NREG];
  int              m_init;
  bit              m_known = 1'b0;

  always #5 clk = ~clk;

  rf_scoreboard #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy), .ready(b_ready)
  );

  rf_scoreboard #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(n_rs1_data), .rs2_data(n_rs2_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .rs1_busy(n_rs1_busy), .rs2_busy(n_rs2_busy), .ready(n_ready)
  );

  task automatic check_val(input string tag, input logic [XLEN-1:0] obs,
                           input logic [XLEN-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
    if (m_init != 0 || a == 0) return '0;
    if (byp && wr_en && wr_addr == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
    if (m_init != 0 || a == 0) return 1'b0;
    if (byp && wr_en && wr_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  // Compare all outputs, then advance the model by the upcoming edge
  task automatic tick();
    @(negedge clk);
    if (m_known) begin
      check_val("b_rs1_data", b_rs1_data, exp_data(rs1_addr, 1'b1));
      check_val("b_rs2_data", b_rs2_data, exp_data(rs2_addr, 1'b1));
      check_val("n_rs1_data", n_rs1_data, exp_data(rs1_addr, 1'b0));
      check_val("n_rs2_data", n_rs2_data, exp_data(rs2_addr, 1'b0));
      check_val("b_rs1_busy", 32'(b_rs1_busy), 32'(exp_busy(rs1_addr, 1'b1)));
      check_val("b_rs2_busy", 32'(b_rs2_busy), 32'(exp_busy(rs2_addr, 1'b1)));
      check_val("n_rs1_busy", 32'(n_rs1_busy), 32'(exp_busy(rs1_addr, 1'b0)));
      check_val("n_rs2_busy", 32'(n_rs2_busy), 32'(exp_busy(rs2_addr, 1'b0)));
      check_val("b_ready", 32'(b_ready), 32'(m_init == 0));
      check_val("n_ready", 32'(n_ready), 32'(m_init == 0));
    end
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
      m_init  = NREG;
      m_known = 1'b1;
    end else if (m_init > 0) begin
      m_init--;
    end else begin
      if (wr_en && wr_addr != 0) begin
        m_mem[wr_addr]  = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; issue_en = 1'b0; wr_addr = '0; issue_rd = '0; wr_data = '0;
  endtask

  initial begin
    int cyc;
    rst = 1'b1; rs1_addr = '0; rs2_addr = '0;
    idle();
    @(posedge clk); #1;
    repeat (3) tick();

    // Init sweep length, with a write that must be ignored
    rst = 1'b0; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    issue_en = 1'b1; issue_rd = 5'd6; rs1_addr = 5'd5;
    cyc = 0;
    while (!b_ready && cyc < 100) begin
      tick();
      cyc++;
    end
    check_val("init_cycles", 32'(cyc), 32'd32);
    idle(); rs1_addr = 5'd5; rs2_addr = 5'd6;
    #1;
    check_val("x5_after_init", b_rs1_data, 32'h0);
    check_val("x6_busy_after_init", 32'(b_rs2_busy), 32'h0);
    tick();

    // Write x7, read on both ports; write x0 is discarded
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678; tick();
    idle(); rs1_addr = 5'd7; rs2_addr = 5'd7; #1;
    check_val("x7_rs1", b_rs1_data, 32'h12345678);
    check_val("x7_rs2", b_rs2_data, 32'h12345678);
    tick();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; tick();
    idle(); rs1_addr = 5'd0; #1;
    check_val("x0_zero", b_rs1_data, 32'h0);
    tick();

    // Same-cycle forwarding vs stored value
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5A5A5; rs2_addr = 5'd3; #1;
    check_val("bypass_on", b_rs2_data, 32'hA5A5A5A5);
    check_val("bypass_off", n_rs2_data, 32'h0);
    tick();

    // Scoreboard set, set-wins collision, clear, and x0 never busy
    idle(); issue_en = 1'b1; issue_rd = 5'd9; tick();
    idle(); rs1_addr = 5'd9; #1;
    check_val("busy9_set", 32'(b_rs1_busy), 32'd1);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99; issue_en = 1'b1; issue_rd = 5'd9;
    tick();
    idle(); rs1_addr = 5'd9; #1;
    check_val("busy9_setwins", 32'(b_rs1_busy), 32'd1);
    check_val("busy9_setwins_nb", 32'(n_rs1_busy), 32'd1);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h9A; tick();
    idle(); #1;
    check_val("busy9_clear", 32'(b_rs1_busy), 32'd0);
    issue_en = 1'b1; issue_rd = 5'd0; tick();
    idle(); rs1_addr = 5'd0; #1;
    check_val("busy0", 32'(b_rs1_busy), 32'd0);
    tick();

    // Reset in RUN with x4 busy and non-zero, write in the reset cycle
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h55; tick();
    idle(); issue_en = 1'b1; issue_rd = 5'd4; tick();
    idle(); rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h77; tick();
    rst = 1'b0; idle(); rs1_addr = 5'd4; #1;
    check_val("ready_drop", 32'(b_ready), 32'd0);
    check_val("busy4_cleared", 32'(b_rs1_busy), 32'd0);
    repeat (NREG) tick();
    #1;
    check_val("ready_again", 32'(b_ready), 32'd1);
    check_val("x4_rezeroed", b_rs1_data, 32'h0);
    check_val("busy4_after", 32'(b_rs1_busy), 32'd0);

    // Randomised traffic, biased to a few registers to provoke collisions
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      wr_en    = ($urandom_range(0, 1) == 1);
      issue_en = ($urandom_range(0, 2) == 0);
      wr_addr  = AW'($urandom_range(0, 7));
      issue_rd = AW'($urandom_range(0, 7));
      rs1_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      rs2_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      wr_data  = $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/rf_scoreboard.md
Name: rf_scoreboard

Overview:
- Parametrised successor to the single-cycle core's register file, for the pipelined RV32 core.
- Provides two combinational read ports, one synchronous write port, and optional write-to-read bypass.
- Includes a per-register busy scoreboard for hazard detection, and a sequential init sweep after reset so the storage can map to RAM.
- Register 0 is hardwired to zero.

Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of architectural registers; power of two, at least 2.
- AW, $clog2(NREG), register address width.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports; when 0 reads return stored data only.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- rs1_addr  in  AW  read port 1 address.
- rs2_addr  in  AW  read port 2 address.
- rs1_data  out  XLEN  read port 1 data (combinational).
- rs2_data  out  XLEN  read port 2 data (combinational).
- wr_en  in  1  write enable.
- wr_addr  in  AW  write address.
- wr_data  in  XLEN  write data.
- issue_en  in  1  a producer instruction is issued.
- issue_rd  in  AW  destination of the issued instruction.
- rs1_busy  out  1  rs1 has a pending producer.
- rs2_busy  out  1  rs2 has a pending producer.
- ready  out  1  init sweep done; block accepts operations.

Behaviour:
- Reset: synchronous, active-high, on clk rising edge only.
  - rst=1 forces state INIT, init counter to 0, every busy bit to 0, and ready to 0.
  - rst held high keeps the counter at 0.
- State machine with two states, INIT and RUN.
  - INIT: each cycle writes 0 to entry cnt, then cnt increments. When cnt=NREG-1 is written, the next state is RUN. INIT lasts exactly NREG cycles after rst deasserts.
  - ready=1 only in RUN. It is registered and rises on the edge that completes entry NREG-1.
- During INIT:
  - wr_en and issue_en are ignored.
  - rs1_data and rs2_data return 0.
  - rs1_busy and rs2_busy return 0.
- RUN, write: if wr_en=1 and wr_addr!=0, entry wr_addr takes wr_data at the edge. Writes to address 0 are discarded.
- RUN, read: rsN_data = 0 if rsN_addr=0; otherwise it equals the stored entry.
  - If BYPASS=1 and wr_en=1, wr_addr=rsN_addr and wr_addr!=0, rsN_data=wr_data in the same cycle (zero-cycle forwarding).
- Scoreboard (RUN only):
  - Set busy[issue_rd] when issue_en=1 and issue_rd!=0.
  - Clear busy[wr_addr] when wr_en=1 and wr_addr!=0.
  - Set and clear of the same register in one cycle: set wins (new producer outstanding).
  - Set and clear of different registers in one cycle: both apply.
  - busy[0] is always 0.
- Busy outputs: rsN_busy = busy[rsN_addr].
  - If BYPASS=1, a same-cycle write clears the indication: rsN_busy=0 when wr_en=1, wr_addr=rsN_addr and wr_addr!=0.
  - If BYPASS=0, rsN_busy reflects registered busy only, so the consumer stalls one extra cycle.
- Widths:
  - No truncation; all addresses are AW bits wide.
  - Address values of NREG or more cannot occur because NREG is a power of two.
- Reset mid-operation: rst in RUN aborts everything next edge. A write in that same cycle is discarded. Contents are re-zeroed by the new sweep.

Test Plan:
- Deassert rst after 3 cycles. Count cycles to ready: exactly 32 (NREG=32). During this, wr_en=1 wr_addr=5 wr_data=0xDEADBEEF is ignored, and after ready, reading rs1_addr=5 returns 0.
- In RUN, write x7=0x12345678 and then read rs1_addr=7, rs2_addr=7: both return 0x12345678. Write x0=0xFFFFFFFF: reading x0 returns 0.
- Bypass: same cycle wr_en=1 wr_addr=3 wr_data=0xA5A5A5A5 and rs2_addr=3 gives rs2_data=0xA5A5A5A5 combinationally with BYPASS=1. With BYPASS=0 it shows the old value, 0.
- Scoreboard: issue_en issue_rd=9 then rs1_addr=9 gives rs1_busy=1 next cycle. wr_en wr_addr=9 with issue_en issue_rd=9 in the same cycle leaves busy[9]=1. A later write alone clears it to 0. issue_rd=0 never sets busy.
- Assert rst for 1 cycle while busy[4]=1 and x4=0x55: ready drops next edge, busy[4]=0, and after 32 cycles x4 reads 0.
